// File: rtl/rr_arb_4to1_pkg.sv
// Shared constants, types and the round-robin pick function for the 4-to-1 arbiter.
package rr_arb_4to1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NUM_REQ    = 4;
    localparam int SEL_W      = 2;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_t;

    // Pointer value after reset: the search then starts at requester 0.
    localparam sel_t PTR_RST = sel_t'(NUM_REQ - 1);

    // Returns the first requester with valid set, searching ptr+1, ptr+2,
    // ptr+3, ptr (mod 4). With nothing valid the result is ptr+1, so the
    // mux select stays well defined on idle cycles.
    function automatic sel_t rr_pick(input req_t valid, input sel_t ptr);
        sel_t idx;
        sel_t pick;
        logic found;
        pick  = ptr + sel_t'(1);
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + sel_t'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb_4to1_mux.sv
// Plain 4-input payload multiplexer; the arbiter's datapath select.
module mux_4to1
    import rr_arb_4to1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    // Route the selected input straight through; no arithmetic on payload.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/rr_arb_4to1.sv
// Round-robin 4-to-1 arbiter feeding a one-entry output register.
// The grant is combinational from the pointer; the output stage reloads
// whenever it is empty or being drained, so it sustains one beat per cycle.
module rr_arb_4to1
    import rr_arb_4to1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data0,
    input  logic [DATA_W-1:0]   in_data1,
    input  logic [DATA_W-1:0]   in_data2,
    input  logic [DATA_W-1:0]   in_data3,
    input  logic [NUM_REQ-1:0]  in_valid,
    output logic [NUM_REQ-1:0]  in_ready,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    out_src,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [DATA_W-1:0]  r_out_data;
    logic [SEL_W-1:0]   r_out_src;
    logic               r_out_valid;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_load_en;
    logic               w_any_valid;
    logic [SEL_W-1:0]   w_sel;
    logic [DATA_W-1:0]  w_mux_out;
    logic [NUM_REQ-1:0] w_in_ready;

    // The output register can take a new beat when empty or when drained this cycle.
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_any_valid = |in_valid;

    // Grant index; falls back to ptr+1 when nobody is requesting.
    always_comb begin
        w_sel = rr_pick(in_valid, r_ptr);
    end

    // Only the granted requester sees ready, and only when the stage can load.
    // Reset masks ready so nothing is consumed while the beat is being discarded.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign w_in_ready[gi] = !rst && w_load_en && in_valid[gi]
                                    && (w_sel == sel_t'(gi));
        end
    endgenerate

    mux_4to1 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .in0 (in_data0),
        .in1 (in_data1),
        .in2 (in_data2),
        .in3 (in_data3),
        .sel (w_sel),
        .out (w_mux_out)
    );

    // Output stage and pointer: load the granted beat, drain to empty, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= PTR_RST;
        end else if (w_load_en) begin
            if (w_any_valid) begin
                r_out_data  <= w_mux_out;
                r_out_src   <= w_sel;
                r_out_valid <= 1'b1;
                r_ptr       <= w_sel;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign sel       = w_sel;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for the round-robin 4-to-1 arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_rr_arb_4to1;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_valid;
    logic          out_ready;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [DW-1:0] pay [4];

    rr_arb_4to1 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous monitor: in_ready one-hot-or-zero every cycle, and every load
    // must land with out_src equal to the sel seen in the loading cycle.
    logic       pend_load = 1'b0;
    logic [1:0] pend_sel  = 2'd0;
    always @(negedge clk) begin
        if (pend_load) begin
            vec_cnt++;
            if (out_src !== pend_sel || out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL load_src: out_src=%0d out_valid=%b required src=%0d valid=1",
                         out_src, out_valid, pend_sel);
            end
        end
        vec_cnt++;
        if (!$onehot0(in_ready)) begin
            err_cnt++;
            $display("FAIL ready_onehot: in_ready=%b required one-hot or zero", in_ready);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0)
            $display("xfer src=%0d data=%h", out_src, out_data);
        pend_load = (rst === 1'b0) && (in_ready != 4'b0000);
        pend_sel  = sel;
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        drive_edge();
        drive_edge();
        in_valid = 4'b1111;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b need 0", out_valid); end
        vec_cnt++;
        if (out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h need 00", out_data); end
        vec_cnt++;
        if (out_src !== 2'd0) begin err_cnt++; $display("FAIL rst_src: got %0d need 0", out_src); end
        vec_cnt++;
        if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_ready: got %b need 0000", in_ready); end
        vec_cnt++;
        if (sel !== 2'd0) begin err_cnt++; $display("FAIL rst_sel: got %0d need 0 (ptr=3)", sel); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        drive_edge();
        rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                vec_cnt++;
                if (out_valid !== 1'b1 || out_src !== 2'((k - 1) % 4) || out_data !== pay[(k - 1) % 4]) begin
                    err_cnt++;
                    $display("FAIL fair_out%0d: got v=%b src=%0d data=%h need v=1 src=%0d data=%h",
                             k, out_valid, out_src, out_data, (k - 1) % 4, pay[(k - 1) % 4]);
                end
            end else begin
                vec_cnt++;
                if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fair_lat: out_valid=%b need 0", out_valid); end
            end
            if (k < 5) begin
                exp_rdy = 4'b0001 << (k % 4);
                vec_cnt++;
                if (in_ready !== exp_rdy) begin
                    err_cnt++;
                    $display("FAIL fair_rdy%0d: got %b need %b", k, in_ready, exp_rdy);
                end
            end
        end
    endtask

    task automatic test_single();
        drive_edge();
        in_valid = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 4'b0100 || sel !== 2'd2) begin
            err_cnt++; $display("FAIL single_rdy: got rdy=%b sel=%0d need 0100 sel=2", in_ready, sel);
        end
        drive_edge();
        in_valid = 4'b0000;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'hC2) begin
            err_cnt++; $display("FAIL single_out: got v=%b src=%0d data=%h need v=1 src=2 data=c2",
                                out_valid, out_src, out_data);
        end
        vec_cnt++;
        if (sel !== 2'd3 || in_ready !== 4'b0000) begin
            err_cnt++; $display("FAIL idle_sel: got sel=%0d rdy=%b need sel=3 rdy=0000", sel, in_ready);
        end
        drive_edge();
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || out_src !== 2'd2 || out_data !== 8'hC2 || sel !== 2'd3) begin
            err_cnt++; $display("FAIL drain_hold: got v=%b src=%0d data=%h sel=%0d need v=0 src=2 data=c2 sel=3",
                                out_valid, out_src, out_data, sel);
        end
    endtask

    task automatic test_backpressure();
        drive_edge();
        in_valid = 4'b0010; out_ready = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 4'b0010) begin err_cnt++; $display("FAIL bp_load: got %b need 0010", in_ready); end
        drive_edge();
        in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_src !== 2'd1 || in_ready !== 4'b0000) begin
                err_cnt++; $display("FAIL bp_hold%0d: got v=%b data=%h src=%0d rdy=%b need v=1 data=b1 src=1 rdy=0000",
                                    c, out_valid, out_data, out_src, in_ready);
            end
            if (c < 2) drive_edge();
        end
        drive_edge();
        out_ready = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hB1) begin
            err_cnt++; $display("FAIL bp_release: got rdy=%b sel=%0d data=%h need 0100 sel=2 data=b1",
                                in_ready, sel, out_data);
        end
        drive_edge();
        in_valid = 4'b0000;
        @(negedge clk);
        vec_cnt++;
        if (out_src !== 2'd2 || out_data !== 8'hC2) begin
            err_cnt++; $display("FAIL bp_next: got src=%0d data=%h need src=2 data=c2", out_src, out_data);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] g [4];
        logic [3:0] exp_rdy;
        g[0] = 2'd0; g[1] = 2'd3; g[2] = 2'd0; g[3] = 2'd3;
        drive_edge();
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        drive_edge();
        rst = 1'b0; in_valid = 4'b1001;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                vec_cnt++;
                if (out_src !== g[k - 1] || out_data !== pay[g[k - 1]]) begin
                    err_cnt++; $display("FAIL wrap_out%0d: got src=%0d data=%h need src=%0d data=%h",
                                        k, out_src, out_data, g[k - 1], pay[g[k - 1]]);
                end
            end
            if (k < 3) begin
                exp_rdy = 4'b0001 << g[k];
                vec_cnt++;
                if (in_ready !== exp_rdy) begin
                    err_cnt++; $display("FAIL wrap_rdy%0d: got %b need %b", k, in_ready, exp_rdy);
                end
            end
        end
        drive_edge();
        in_valid = 4'b0000;
        drive_edge();
    endtask

    task automatic test_reset_midbeat();
        in_valid = 4'b1000; out_ready = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 4'b1000) begin err_cnt++; $display("FAIL mid_load: got %b need 1000", in_ready); end
        drive_edge();
        in_valid = 4'b0000; rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hD3 || in_ready !== 4'b0000) begin
            err_cnt++; $display("FAIL mid_held: got v=%b data=%h rdy=%b need v=1 data=d3 rdy=0000",
                                out_valid, out_data, in_ready);
        end
        drive_edge();
        rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            err_cnt++; $display("FAIL mid_discard: got v=%b data=%h src=%0d need v=0 data=00 src=0",
                                out_valid, out_data, out_src);
        end
        vec_cnt++;
        if (in_ready !== 4'b0001 || sel !== 2'd0) begin
            err_cnt++; $display("FAIL mid_first: got rdy=%b sel=%0d need 0001 sel=0", in_ready, sel);
        end
        drive_edge();
        in_valid = 4'b0000;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hA0) begin
            err_cnt++; $display("FAIL mid_after: got v=%b src=%0d data=%h need v=1 src=0 data=a0",
                                out_valid, out_src, out_data);
        end
    endtask

    initial begin
        pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2; pay[3] = 8'hD3;
        in_data0 = pay[0]; in_data1 = pay[1]; in_data2 = pay[2]; in_data3 = pay[3];
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_wrap();
        test_reset_midbeat();
        drive_edge();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arb_4to1.md
RR_ARB_4TO1 -- requirements
Module: rr_arb_4to1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width; SHALL equal the mux_4to1 data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_data0..in_data3  input  DATA_W each  requester payloads.
REQ-005 SHALL have port in_valid  input  4  per-requester valid; bit i qualifies in_data i.
REQ-006 SHALL have port in_ready  output  4  per-requester accept; one-hot or zero.
REQ-007 SHALL have port sel  output  2  combinational grant index; drives the mux select.
REQ-008 SHALL have port out_data  output  DATA_W  registered selected payload.
REQ-009 SHALL have port out_src  output  2  registered index of the source held in out_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_src hold a valid beat.
REQ-011 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-012 A transfer on requester i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; a transfer downstream SHALL occur where out_valid and out_ready are both 1.
REQ-013 load_en SHALL be (!out_valid || out_ready), giving a one-entry pipeline register that sustains 1 beat/cycle.
REQ-014 Grant SHALL be round-robin from 2-bit pointer ptr: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); the first index with in_valid set is granted.
REQ-015 sel SHALL equal the granted index when any in_valid is set; otherwise sel SHALL equal ptr+1 (mod 4).
REQ-016 in_ready[i] SHALL be 1 only when load_en, in_valid[i], and i is the granted index.
REQ-017 On a load, out_data SHALL take the mux output for sel, out_src SHALL take sel, out_valid SHALL go to 1, and ptr SHALL take sel, all at the next edge.
REQ-018 If load_en and no in_valid is set, out_valid SHALL go to 0 at the next edge; out_data, out_src, and ptr SHALL hold.
REQ-019 If out_valid && !out_ready, out_data, out_src, and out_valid SHALL hold, and in_ready SHALL be 0000 (backpressure).
REQ-020 Latency SHALL be 1 cycle from an upstream transfer to out_valid.
REQ-021 Fairness: with all four in_valid held high and out_ready=1, grants SHALL cycle 0,1,2,3,0,... with no port skipped.
REQ-022 in_valid changing while not granted SHALL have no effect on state.
REQ-023 Payload SHALL pass unmodified; no arithmetic on data. ptr wraps 3->0 naturally in 2 bits.

Reset
REQ-024 While rst=1 at an edge, out_valid SHALL become 0, out_data 0, out_src 0, and ptr 3, so port 0 has first priority after reset.
REQ-025 in_ready SHALL be 0000 while rst=1; any beat held mid-operation SHALL be discarded, not emitted.
REQ-026 The first edge with rst=0 SHALL behave as REQ-013..017 with out_valid=0.

Structure
REQ-027 A shared package SHALL hold DATA_W default, NUM_REQ=4, and SEL_W=2.
REQ-028 The datapath select SHALL be one instance of the existing mux_4to1 (in0..in3, sel, out); arbitration and registers stay in rr_arb_4to1.
REQ-029 The design SHALL have no other sub-modules, no latches, and no asynchronous logic.

Verification
REQ-030 Reset then in_data=A0,B1,C2,D3, in_valid=1111, out_ready=1: out_src sequence 0,1,2,3,0, and out_data A0,B1,C2,D3,A0, first beat one cycle after the first transfer.
REQ-031 in_valid=0100 only, out_ready=1: in_ready=0100, and next cycle out_data=C2, out_src=2, out_valid=1.
REQ-032 Beat B1 held with out_ready=0 for 3 cycles and in_valid=1111: out_data stays B1, in_ready stays 0000, and on release the next grant is 2.
REQ-033 in_valid=1001 with ptr=3: grant 0, then 3, then 0 (wrap-around).
REQ-034 Assert rst for one cycle while out_valid=1 (payload D3): out_valid=0 next cycle, D3 never accepted downstream, and the next grant is port 0.
REQ-035 Throughout all scenarios the bench SHALL check in_ready one-hot-or-zero and sel==out_src on every load.
